// File: rtl/sky130_ef_io__gpio_pkg.sv
// Purpose: shared config-word bit map, reset word and sequencer states for the gpio control block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sky130_ef_io__gpio_pkg;

  localparam int CFG_W = 13;
  localparam logic [CFG_W-1:0] CFG_DEFAULT_WORD = 13'h1801;  // mgmt-owned, input-only

  // Bit positions inside the config word
  localparam int CFG_MGMT_EN     = 12;
  localparam int CFG_OEB         = 11;
  localparam int CFG_HLD_OVR     = 10;
  localparam int CFG_INP_DIS     = 9;
  localparam int CFG_IB_MODE_SEL = 8;
  localparam int CFG_ANALOG_EN   = 7;
  localparam int CFG_ANALOG_SEL  = 6;
  localparam int CFG_ANALOG_POL  = 5;
  localparam int CFG_SLOW        = 4;
  localparam int CFG_VTRIP_SEL   = 3;
  localparam int CFG_DM_LSB      = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_APPLY = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/sky130_ef_io__sync2.sv
// Purpose: two-flop synchroniser bringing an asynchronous level into the core clock domain.
// Latency: 2 clk cycles.
// Backpressure: none.
// Ports: clk, rst_n (async, active-low) | d (async in) | q (synchronised out, resets to 0).
module sky130_ef_io__sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sky130_ef_io__gpio_ctrl.sv
// Purpose: per-pad control for the gpiov2 wrapper: serial daisy-chained config, sequenced mode update, data mux.
// Latency: config reaches pad HOLD_CYCLES+1 cycles after an accepted load; pad input 2 cycles to core.
// Backpressure: loads arriving while busy or before a full word is shifted are dropped and flagged in CFG_ERR.
// Ports: CLK/RESET_N | SER_SHIFT, SER_DATA_IN, SER_LOAD, SER_DATA_OUT, CFG_BUSY, CFG_ERR (config chain)
//        MGMT_OUT/MGMT_IN, USER_OUT/USER_OE_N/USER_IN (core side) | PAD_IN/OUT/OE_N/DM/MODE/ANALOG (pad side)
module sky130_ef_io__gpio_ctrl
  import sky130_ef_io__gpio_pkg::*;
#(
  parameter int                   CFG_WIDTH   = CFG_W,
  parameter logic [CFG_WIDTH-1:0] CFG_DEFAULT = CFG_DEFAULT_WORD,
  parameter int                   HOLD_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       SER_SHIFT,
  input  logic       SER_DATA_IN,
  input  logic       SER_LOAD,
  output logic       SER_DATA_OUT,
  output logic       CFG_BUSY,
  output logic       CFG_ERR,
  input  logic       MGMT_OUT,
  output logic       MGMT_IN,
  input  logic       USER_OUT,
  input  logic       USER_OE_N,
  output logic       USER_IN,
  input  logic       PAD_IN,
  output logic       PAD_OUT,
  output logic       PAD_OE_N,
  output logic [2:0] PAD_DM,
  output logic [4:0] PAD_MODE,
  output logic [2:0] PAD_ANALOG
);

  localparam int                 CNT_W     = $clog2(CFG_WIDTH + 1);
  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(CFG_WIDTH);
  localparam logic [3:0]         HOLD_LAST = 4'(HOLD_CYCLES - 1);

  logic [CFG_WIDTH-1:0] sreg;
  logic [CNT_W-1:0]     bit_cnt;
  logic [CFG_WIDTH-1:0] staging;
  logic [CFG_WIDTH-1:0] shadow;
  logic [3:0]           hold_cnt;
  cfg_state_e           state, state_nxt;
  logic                 busy_q;
  logic                 err_q;
  logic                 load_accept;
  logic                 load_reject;
  logic                 hold_done;
  logic                 pad_in_sync;
  logic                 mgmt_en;

  // FSM: state register. Busy is registered from the next state so it lines up with HOLD/APPLY.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt != ST_IDLE);
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (load_accept) state_nxt = ST_HOLD;
      ST_HOLD:  if (hold_done)   state_nxt = ST_APPLY;
      ST_APPLY: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM: decoded controls. A load is only taken with a complete word and no sequence in flight.
  always_comb begin
    load_accept = 1'b0;
    load_reject = 1'b0;
    hold_done   = 1'b0;
    if (SER_LOAD) begin
      if (state == ST_IDLE && bit_cnt == CNT_FULL) load_accept = 1'b1;
      else                                         load_reject = 1'b1;
    end
    if (state == ST_HOLD && hold_cnt == 4'd0) hold_done = 1'b1;
  end

  // Shift chain, staging/shadow registers and sticky error
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sreg     <= '0;
      bit_cnt  <= '0;
      staging  <= CFG_DEFAULT;
      shadow   <= CFG_DEFAULT;
      hold_cnt <= 4'd0;
      err_q    <= 1'b0;
    end else begin
      if (SER_SHIFT) sreg <= {sreg[CFG_WIDTH-2:0], SER_DATA_IN};

      // A shift in the same cycle as an accepted load counts as the first bit of the next word
      if (load_accept)
        bit_cnt <= {{(CNT_W-1){1'b0}}, SER_SHIFT};
      else if (SER_SHIFT && bit_cnt != CNT_FULL)
        bit_cnt <= bit_cnt + CNT_W'(1);

      if (load_accept) begin
        staging  <= sreg;
        hold_cnt <= HOLD_LAST;
      end else if (state == ST_HOLD && hold_cnt != 4'd0) begin
        hold_cnt <= hold_cnt - 4'd1;
      end

      if (hold_done) shadow <= staging;

      if (load_accept)      err_q <= 1'b0;
      else if (load_reject) err_q <= 1'b1;
    end
  end

  sky130_ef_io__sync2 u_in_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .d     (PAD_IN),
    .q     (pad_in_sync)
  );

  assign mgmt_en      = shadow[CFG_MGMT_EN];
  assign SER_DATA_OUT = sreg[CFG_WIDTH-1];
  assign CFG_BUSY     = busy_q;
  assign CFG_ERR      = err_q;

  // Output stays tristated for the whole update so mode pins never change under a driven pad
  assign PAD_OUT    = mgmt_en ? MGMT_OUT : USER_OUT;
  assign PAD_OE_N   = busy_q | (mgmt_en ? shadow[CFG_OEB] : USER_OE_N);
  assign PAD_DM     = shadow[CFG_DM_LSB +: 3];
  assign PAD_MODE   = {shadow[CFG_HLD_OVR], shadow[CFG_INP_DIS], shadow[CFG_IB_MODE_SEL],
                       shadow[CFG_SLOW], shadow[CFG_VTRIP_SEL]};
  assign PAD_ANALOG = {shadow[CFG_ANALOG_EN], shadow[CFG_ANALOG_SEL], shadow[CFG_ANALOG_POL]};

  assign MGMT_IN = mgmt_en & pad_in_sync;
  assign USER_IN = ~mgmt_en & pad_in_sync;

endmodule

// File: tb/tb_sky130_ef_io__gpio_ctrl.sv
module tb_sky130_ef_io__gpio_ctrl;

  logic clk, rst_n;
  logic ser_shift, ser_din, ser_load;
  logic mgmt_out, user_out, user_oe_n, pad_in;

  logic       ser_out[2], busy[2], err[2], mgmt_in[2], user_in[2], pad_out[2], pad_oe_n[2];
  logic [2:0] dm[2];
  logic [4:0] mode[2];
  logic [2:0] an[2];

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two chained pads: dut1 receives dut0's serial output and uses a long hold window
  sky130_ef_io__gpio_ctrl #(.HOLD_CYCLES(4)) dut0 (
    .CLK(clk), .RESET_N(rst_n), .SER_SHIFT(ser_shift), .SER_DATA_IN(ser_din), .SER_LOAD(ser_load),
    .SER_DATA_OUT(ser_out[0]), .CFG_BUSY(busy[0]), .CFG_ERR(err[0]),
    .MGMT_OUT(mgmt_out), .MGMT_IN(mgmt_in[0]), .USER_OUT(user_out), .USER_OE_N(user_oe_n),
    .USER_IN(user_in[0]), .PAD_IN(pad_in), .PAD_OUT(pad_out[0]), .PAD_OE_N(pad_oe_n[0]),
    .PAD_DM(dm[0]), .PAD_MODE(mode[0]), .PAD_ANALOG(an[0])
  );

  sky130_ef_io__gpio_ctrl #(.HOLD_CYCLES(15)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .SER_SHIFT(ser_shift), .SER_DATA_IN(ser_out[0]), .SER_LOAD(ser_load),
    .SER_DATA_OUT(ser_out[1]), .CFG_BUSY(busy[1]), .CFG_ERR(err[1]),
    .MGMT_OUT(mgmt_out), .MGMT_IN(mgmt_in[1]), .USER_OUT(user_out), .USER_OE_N(user_oe_n),
    .USER_IN(user_in[1]), .PAD_IN(pad_in), .PAD_OUT(pad_out[1]), .PAD_OE_N(pad_oe_n[1]),
    .PAD_DM(dm[1]), .PAD_MODE(mode[1]), .PAD_ANALOG(an[1])
  );

  // ---------------- behavioural model ----------------
  // Timing is tracked as "edges since the accepted load": busy spans offsets 0..hold,
  // the new word lands at offset hold.
  int          cyc;
  logic [12:0] m_bits[2], m_pend[2], m_shadow[2];
  int          m_n[2], m_L[2];
  logic        m_err[2];
  int          m_hold[2];
  logic        smp_last, smp_out, chain_bit;
  logic        m_d, m_busy_before, m_acc;

  initial begin
    m_hold[0] = 4;
    m_hold[1] = 15;
  end

  function automatic logic is_busy(input int i, input int c);
    return (m_L[i] >= 0) && (c >= m_L[i]) && ((c - m_L[i]) <= m_hold[i]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
        m_bits[i] = 13'h0; m_pend[i] = 13'h1801; m_shadow[i] = 13'h1801;
        m_n[i] = 0; m_L[i] = -1; m_err[i] = 1'b0;
      end
      smp_last = 1'b0;
      smp_out  = 1'b0;
    end else begin
      cyc++;
      chain_bit = m_bits[0][12];
      for (int i = 0; i < 2; i++) begin
        m_d           = (i == 0) ? ser_din : chain_bit;
        m_busy_before = is_busy(i, cyc - 1);
        m_acc         = ser_load && (m_n[i] >= 13) && !m_busy_before;
        if (ser_load && !m_acc) m_err[i] = 1'b1;
        if (m_acc) begin
          m_pend[i] = m_bits[i]; m_L[i] = cyc; m_err[i] = 1'b0; m_n[i] = 0;
        end
        if (ser_shift) begin
          m_bits[i] = {m_bits[i][11:0], m_d};
          if (m_n[i] < 13) m_n[i]++;
        end
        if (m_L[i] >= 0 && (cyc - m_L[i]) == m_hold[i]) m_shadow[i] = m_pend[i];
      end
      smp_out  = smp_last;
      smp_last = pad_in;
    end
  end

  function automatic logic [17:0] model_vec(input int i);
    logic [12:0] sh;
    logic        mg, b;
    sh = m_shadow[i];
    mg = sh[12];
    b  = is_busy(i, cyc);
    return {m_bits[i][12], b, m_err[i], (mg ? mgmt_out : user_out), b | (mg ? sh[11] : user_oe_n),
            sh[2:0], sh[10], sh[9], sh[8], sh[4], sh[3], sh[7:5], mg & smp_out, ~mg & smp_out};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [17:0] got, exp_v;
      got   = {ser_out[i], busy[i], err[i], pad_out[i], pad_oe_n[i], dm[i], mode[i], an[i],
               mgmt_in[i], user_in[i]};
      exp_v = model_vec(i);
      tests++;
      if (got !== exp_v) begin
        fails++;
        $display("FAIL model inst%0d cyc%0d: got=%05h exp=%05h", i, cyc, got, exp_v);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    tests++;
    if (got !== exp_v) begin
      fails++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic shift_bits(input logic [12:0] w, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      ser_shift = 1'b1;
      ser_din   = w[k];
      tick();
    end
    ser_shift = 1'b0;
  endtask

  task automatic pulse_load();
    ser_load = 1'b1;
    tick();
    ser_load = 1'b0;
  endtask

  initial begin
    int bc;
    rst_n = 1'b0; ser_shift = 1'b0; ser_din = 1'b0; ser_load = 1'b0;
    mgmt_out = 1'b0; user_out = 1'b0; user_oe_n = 1'b1; pad_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_oe_n",   32'(pad_oe_n[0]), 32'(1'b1));
    check("rst_dm",     32'(dm[0]),       32'(3'b001));
    check("rst_mode",   32'(mode[0]),     32'(5'b00000));
    check("rst_analog", 32'(an[0]),       32'(3'b000));
    check("rst_busy",   32'(busy[0]),     32'(1'b0));
    check("rst_err",    32'(err[0]),      32'(1'b0));
    rst_n = 1'b1;
    tick();

    // Basic load of 13'h0403: busy window, mode update in APPLY, OE_N release after
    user_oe_n = 1'b0;
    user_out  = 1'b1;
    shift_bits(13'h0403, 13);
    pulse_load();
    bc = 0;
    for (int j = 0; j < 8; j++) begin
      if (busy[0]) bc++;
      if (j == 3) check("hold_dm_old", 32'(dm[0]), 32'(3'b001));
      if (j == 4) begin
        check("apply_dm",   32'(dm[0]),       32'(3'b011));
        check("apply_oe_n", 32'(pad_oe_n[0]), 32'(1'b1));
      end
      if (j == 5) check("release_oe_n", 32'(pad_oe_n[0]), 32'(1'b0));
      tick();
    end
    check("busy_cycles", 32'(bc), 32'(5));
    check("user_out_hi", 32'(pad_out[0]), 32'(1'b1));
    user_out = 1'b0;
    #1;
    check("user_out_lo", 32'(pad_out[0]), 32'(1'b0));
    check("mode_0403",   32'(mode[0]),    32'(5'b10000));
    pad_in = 1'b1;
    idle(3);
    check("user_in",      32'(user_in[0]), 32'(1'b1));
    check("mgmt_in_gate", 32'(mgmt_in[0]), 32'(1'b0));
    pad_in = 1'b0;
    idle(20);

    // Daisy chain: dut1 word first, dut0 word last
    mgmt_out = 1'b1;
    shift_bits(13'h0C2A, 13);
    shift_bits(13'h1006, 13);
    check("chain_out0", 32'(ser_out[0]), 32'(1'b1));
    check("chain_out1", 32'(ser_out[1]), 32'(1'b0));
    pulse_load();
    idle(20);
    check("d0_dm",     32'(dm[0]),       32'(3'b110));
    check("d0_oe_n",   32'(pad_oe_n[0]), 32'(1'b0));
    check("d0_out",    32'(pad_out[0]),  32'(1'b1));
    check("d1_dm",     32'(dm[1]),       32'(3'b010));
    check("d1_mode",   32'(mode[1]),     32'(5'b10001));
    check("d1_analog", 32'(an[1]),       32'(3'b001));
    check("d1_oe_n",   32'(pad_oe_n[1]), 32'(1'b0));

    // Short word rejected, completed word accepted
    shift_bits(13'h0888, 12);
    pulse_load();
    check("short_err",  32'(err[0]), 32'(1'b1));
    check("short_keep", 32'(dm[0]),  32'(3'b110));
    shift_bits(13'h1111, 1);
    pulse_load();
    check("full_err_clr", 32'(err[0]), 32'(1'b0));
    idle(20);
    check("full_mode", 32'(mode[0]), 32'(5'b00110));
    check("full_dm",   32'(dm[0]),   32'(3'b001));

    // Shift+load in one cycle, then a load while dut1 is still busy
    shift_bits(13'h0A4B, 13);
    ser_shift = 1'b1; ser_din = 1'b1; ser_load = 1'b1;
    tick();
    ser_shift = 1'b0; ser_load = 1'b0;
    shift_bits(13'h1F80, 12);
    check("pre_shift_dm",   32'(dm[0]),   32'(3'b011));
    check("pre_shift_mode", 32'(mode[0]), 32'(5'b01001));
    check("d1_still_busy",  32'(busy[1]), 32'(1'b1));
    pulse_load();
    check("busy_reject_err", 32'(err[1]), 32'(1'b1));
    check("cnt_one_accept",  32'(err[0]), 32'(1'b0));
    idle(20);
    check("busy_keep_dm",   32'(dm[1]),   32'(3'b001));
    check("busy_keep_mode", 32'(mode[1]), 32'(5'b00110));
    check("err_sticky",     32'(err[1]),  32'(1'b1));

    // Input sync with MGMT_EN=1
    pad_in = 1'b1;
    tick();
    check("sync_lat1", 32'(mgmt_in[0]), 32'(1'b0));
    tick();
    check("sync_lat2",  32'(mgmt_in[0]), 32'(1'b1));
    check("user_in_lo", 32'(user_in[0]), 32'(1'b0));
    pad_in = 1'b0;
    idle(2);
    check("sync_fall", 32'(mgmt_in[0]), 32'(1'b0));

    // Async reset in the middle of HOLD
    shift_bits(13'h0007, 13);
    pulse_load();
    tick();
    check("mid_hold_busy", 32'(busy[0]), 32'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",   32'(busy[0]),     32'(1'b0));
    check("arst_oe_n",   32'(pad_oe_n[0]), 32'(1'b1));
    check("arst_dm",     32'(dm[0]),       32'(3'b001));
    check("arst_mode",   32'(mode[0]),     32'(5'b00000));
    check("arst_analog", 32'(an[0]),       32'(3'b000));
    check("arst_err",    32'(err[1]),      32'(1'b0));
    check("arst_ser",    32'(ser_out[0]),  32'(1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
